mdu_iter: RTL and testbench

- Iterative multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Takes the same 32-bit operand pair and serves MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO through a start/busy/done handshake.
- Results are kept in architectural HI/LO registers.
- The ALU answers combinationally; this block answers after a fixed multi-cycle latency.

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_divstep.sv | 30 +++
 rtl/mdu_iter.sv | 150 +++++++++++++++
 tb/tb_mdu_iter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring shift-subtract divide step
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    // A clear top bit means the trial subtraction did not go negative.
    if (!diff[WIDTH]) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with HI/LO; MDU_FAST_MUL_EN selects a single-cycle multiplier
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, sign_a_q, sign_a_d, sign_b_q, sign_b_d;

  logic [WIDTH-1:0]   div_rem, div_quo, mul_rem, mul_quo;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;
  logic               signed_op, sa, sb;

  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Shift-add step: rem holds the running upper half, quo the multiplier/lower half.
  assign mul_sum = {1'b0, rem_q} + ({1'b0, dvs_q} & {(WIDTH+1){quo_q[0]}});
  assign mul_rem = mul_sum[WIDTH:1];
  assign mul_quo = {mul_sum[0], quo_q[WIDTH-1:1]};

`ifdef MDU_FAST_MUL_EN
  assign prod = {{WIDTH{1'b0}}, dvs_q} * {{WIDTH{1'b0}}, quo_q};
`else
  assign prod = {mul_rem, mul_quo};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    busy      = 1'b0;
    done      = 1'b0;
    signed_op = ~op[0];
    sa        = signed_op & a[WIDTH-1];
    sb        = signed_op & b[WIDTH-1];

    if (state_q == CALC) begin
      busy  = 1'b1;
      cnt_d = cnt_q + CW'(1);
      rem_d = is_div_q ? div_rem : mul_rem;
      quo_d = is_div_q ? div_quo : mul_quo;
      if (cnt_q == CW'(WIDTH-1)) begin
        state_d = FINISH;
        if (!is_div_q) begin
          {hi_d, lo_d} = (sign_a_q ^ sign_b_q) ? -prod : prod;
        end else if (dvs_q == '0) begin
          lo_d = WIDTH'(DIV0_QUOT);
          hi_d = a_q;
        end else begin
          lo_d = (sign_a_q ^ sign_b_q) ? -div_quo : div_quo;
          hi_d = sign_a_q ? -div_rem : div_rem;
        end
      end
    end else begin
      done    = (state_q == FINISH);
      state_d = IDLE;
      if (start) begin
        case (op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            state_d  = CALC;
            is_div_d = op[1];
            sign_a_d = sa;
            sign_b_d = sb;
            a_d      = a;
            rem_d    = '0;
            quo_d    = sa ? -a : a;
            dvs_d    = sb ? -b : b;
            cnt_d    = '0;
`ifdef MDU_FAST_MUL_EN
            if (!op[1]) cnt_d = CW'(WIDTH-1);
`endif
          end
          OP_MTHI: begin
            hi_d    = a;
            state_d = FINISH;
          end
          OP_MTLO: begin
            lo_d    = a;
            state_d = FINISH;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - scoreboard bench for mdu_iter with directed vectors
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk, rst_n, start, busy, done;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;

  int n_total = 0;
  int n_pass  = 0;
  logic [63:0] exp_q[$];

  mdu_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 with hi=%0h lo=%0h, required no pulse", hi, lo);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("hi", {32'h0, hi}, {32'h0, e[63:32]});
        check("lo", {32'h0, lo}, {32'h0, e[31:0]});
      end
    end
  end

  // Caller sits at a negedge; start is sampled on the following posedge.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp_hl,
                        input int exp_lat, input int pulse_at);
    int k;
    int nb;
    exp_q.push_back(exp_hl);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    nb = 0;
    while (!done && k < 100) begin
      if (busy) nb++;
      if (k == pulse_at) begin
        start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(k), 64'(exp_lat));
    check({name, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_hi", {32'h0, hi}, 64'h0);
    check("rst_lo", {32'h0, lo}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    start = 1'b1; op = 3'b110; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("nop_busy", {63'h0, busy}, 64'h0);
    check("nop_done", {63'h0, done}, 64'h0);

    run_op("mult_neg",  3'b000, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, MUL_LAT, -1);
    run_op("divu",      3'b011, 32'd100,      32'd7,        64'h00000002_0000000E, 32, -1);
    run_op("div_neg",   3'b010, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 32, -1);
    run_op("div_ovf",   3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32, -1);
    run_op("divu_by0",  3'b011, 32'h00001234, 32'd0,        64'h00001234_FFFFFFFF, 32, -1);
    run_op("div_by0",   3'b010, 32'hFFFFFFF0, 32'd0,        64'hFFFFFFF0_FFFFFFFF, 32, -1);
    run_op("mult_min",  3'b000, 32'h80000000, 32'h80000000, 64'h40000000_00000000, MUL_LAT, -1);
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, MUL_LAT, 10);
    run_op("mthi",      3'b100, 32'hDEADBEEF, 32'd0,        64'hDEADBEEF_00000001, 0, -1);
    run_op("mtlo",      3'b101, 32'h00000005, 32'd0,        64'hDEADBEEF_00000005, 0, -1);

    start = 1'b1; op = 3'b010; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_hi", {32'h0, hi}, 64'h0);
    check("abort_lo", {32'h0, lo}, 64'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    run_op("mult_small", 3'b000, 32'd6, 32'd7, 64'h00000000_0000002A, MUL_LAT, -1);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
